// File: rtl/ctrl_defs.sv
// rtl/ctrl_defs.sv - shared encodings for the multi-cycle control unit
// Holds state encodings, opcode constants, ALUop constants (also consumed by
// alu_control), alu_src_b / pc_source encodings and the instruction classes
// produced by ctrl_opcode_decode. No ports.
package ctrl_defs;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_I   = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_BNE = 3'd5,
        CLS_J   = 3'd6,
        CLS_ILL = 3'd7
    } instr_class_e;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// rtl/ctrl_opcode_decode.sv - combinational opcode to instruction class decoder
// Ports:
//   opcode  in  6  IR[31:26]
//   cls     out    instruction class (CLS_ILL for anything unsupported)
//   i_aluop out 3  ALUop for I-type arithmetic (add for non I-type opcodes)
module ctrl_opcode_decode
    import ctrl_defs::*;
(
    input  logic [5:0]   opcode,
    output instr_class_e cls,
    output logic [2:0]   i_aluop
);

    always_comb begin
        cls     = CLS_ILL;
        i_aluop = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: cls = CLS_R;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_ADDI:  cls = CLS_I;
            OP_ANDI: begin
                cls     = CLS_I;
                i_aluop = ALUOP_AND;
            end
            OP_ORI: begin
                cls     = CLS_I;
                i_aluop = ALUOP_OR;
            end
            OP_SLTI: begin
                cls     = CLS_I;
                i_aluop = ALUOP_SLT;
            end
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            default:  cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle main control unit
// Sequences each instruction through fetch/decode/execute/mem/writeback and
// drives all datapath strobes plus ALUop for alu_control.
// Optional feature macro: PERF_CNT_EN (adds the retired-instruction counter
// and the retired port; CNT_W sets its width).
// Ports:
//   clk, rst_n (async, active-low)
//   opcode[5:0], zero, mem_ready                       inputs
//   pc_write, ir_write, iord, mem_read, mem_write,
//   reg_write, reg_dst, mem_to_reg, alu_src_a,
//   alu_src_b[1:0], pc_source[1:0], ALUop[2:0]         datapath controls
//   illegal                                            sticky unsupported-opcode flag
//   retired[CNT_W-1:0]                                 PERF_CNT_EN only
module multicycle_control_fsm
    import ctrl_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       ALUop,
    output logic             illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    state_e       state_q, state_d;
    logic         illegal_q, illegal_d;
    instr_class_e cls;
    logic [2:0]   i_aluop;

    ctrl_opcode_decode u_decode (
        .opcode  (opcode),
        .cls     (cls),
        .i_aluop (i_aluop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Raised on the edge that enters TRAP; TRAP is only left through reset.
    assign illegal_d = illegal_q | (state_d == S_TRAP);
    assign illegal   = illegal_q;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_source  = PCSRC_ALU;
        ALUop      = ALUOP_ADD;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every fetch cycle, but PC and IR only load
                // in the cycle memory actually returns the instruction.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_source = PCSRC_ALU;
                ALUop     = ALUOP_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                ALUop     = ALUOP_ADD;
                case (cls)
                    CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
                    CLS_R:            state_d = S_R_EXEC;
                    CLS_I:            state_d = S_I_EXEC;
                    CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
                    CLS_J:            state_d = S_JUMP;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ALUop     = ALUOP_ADD;
                state_d   = (cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                ALUop     = ALUOP_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ALUop     = i_aluop;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                ALUop     = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (cls == CLS_BNE) ? ~zero : zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retired_q, retired_d;

    // A retirement is the last cycle of an instruction, i.e. the cycle whose
    // exit edge returns the FSM to FETCH.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR: retire = mem_ready;
            default:  retire = 1'b0;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          zero, mem_ready;
    logic          pc_write, ir_write, iord, mem_read, mem_write;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, pc_source;
    logic [2:0]    ALUop;
    logic          illegal;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .ALUop      (ALUop),
        .illegal    (illegal)
`ifdef PERF_CNT_EN
        ,
        .retired    (retired)
`endif
    );

`ifndef PERF_CNT_EN
    assign retired = '0;
`endif

    typedef struct packed {
        logic       pc_write, ir_write, iord, mem_read, mem_write;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic [2:0] aluop;
        logic       illegal;
    } outs_t;

    outs_t         exp_q[$];
    logic [CW-1:0] exp_cnt_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          m_illegal;
    int unsigned   m_retired;

    function automatic outs_t mk(input logic pcw, input logic irw, input logic ior,
                                 input logic mrd, input logic mwr, input logic rw,
                                 input logic rdst, input logic m2r, input logic asa,
                                 input logic [1:0] asb, input logic [1:0] pcs,
                                 input logic [2:0] aop);
        mk = {pcw, irw, ior, mrd, mwr, rw, rdst, m2r, asa, asb, pcs, aop, 1'b0};
    endfunction

    function automatic logic r1();
        r1 = 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] r6();
        r6 = 6'($urandom);
    endfunction

    // One clock of stimulus plus the response that cycle must show.
    task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                       input logic mr, input logic z, input outs_t e, input logic ret);
        outs_t ee;
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        if (!rst) begin
            m_illegal = 1'b0;
            m_retired = 0;
        end
        ee         = e;
        ee.illegal = m_illegal;
        exp_q.push_back(ee);
        exp_cnt_q.push_back(CW'(m_retired));
        name_q.push_back(nm);
        if (ret) m_retired++;
    endtask

    // Whole instruction: fw fetch stall cycles, mw memory stall cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        outs_t none;
        logic [2:0] iop;
        none = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", 1, r6(), 1'b0, r1(), mk(0,0,0,1,0,0,0,0,0,2'b01,2'b00,3'b000), 0);
        cyc("fetch", 1, r6(), 1'b1, r1(), mk(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b000), 0);
        cyc("decode", 1, op, r1(), r1(), mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000), 0);
        case (op)
            6'b100011: begin
                cyc("lw_addr", 1, op, r1(), r1(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000), 0);
                for (int i = 0; i < mw; i++)
                    cyc("mem_rd_wait", 1, op, 1'b0, r1(), mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000), 0);
                cyc("mem_rd", 1, op, 1'b1, r1(), mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000), 0);
                cyc("mem_wb", 1, op, r1(), r1(), mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000), 1);
            end
            6'b101011: begin
                cyc("sw_addr", 1, op, r1(), r1(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000), 0);
                for (int i = 0; i < mw; i++)
                    cyc("mem_wr_wait", 1, op, 1'b0, r1(), mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000), 0);
                cyc("mem_wr", 1, op, 1'b1, r1(), mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000), 1);
            end
            6'b000000: begin
                cyc("r_exec", 1, op, r1(), r1(), mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111), 0);
                cyc("r_wb", 1, op, r1(), r1(), mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000), 1);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                iop = (op == 6'b001100) ? 3'b100 :
                      (op == 6'b001101) ? 3'b101 :
                      (op == 6'b001010) ? 3'b110 : 3'b000;
                cyc("i_exec", 1, op, r1(), r1(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,iop), 0);
                cyc("i_wb", 1, op, r1(), r1(), mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000), 1);
            end
            6'b000100:
                cyc("beq", 1, op, r1(), z, mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001), 1);
            6'b000101:
                cyc("bne", 1, op, r1(), z, mk(~z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001), 1);
            6'b000010:
                cyc("jump", 1, op, r1(), r1(), mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000), 1);
            default: begin
                m_illegal = 1'b1;
                for (int i = 0; i < 20; i++)
                    cyc("trap", 1, op, r1(), r1(), none, 0);
            end
        endcase
    endtask

    outs_t         mon_e, mon_act;
    logic [CW-1:0] mon_c;
    string         mon_n;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_c   = exp_cnt_q.pop_front();
            mon_n   = name_q.pop_front();
            mon_act = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, pc_source, ALUop, illegal};
            n_checks++;
            if (mon_act !== mon_e) begin
                n_fail++;
                $display("FAIL %s @%0t: outputs got %b expected %b", mon_n, $time, mon_act, mon_e);
            end
`ifdef PERF_CNT_EN
            n_checks++;
            if (retired !== mon_c) begin
                n_fail++;
                $display("FAIL %s_retired @%0t: got %0d expected %0d", mon_n, $time, retired, mon_c);
            end
`endif
        end
    end

    logic [5:0] legal_ops [10];
    outs_t      zero_e;

    initial begin
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                      6'b001101, 6'b001010, 6'b000100, 6'b000101, 6'b000010};
        zero_e    = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        m_illegal = 1'b0; m_retired = 0;

        repeat (3) cyc("reset", 0, 6'd0, 1'b1, 1'b0, zero_e, 0);
        cyc("idle", 1, r6(), r1(), r1(), zero_e, 0);

        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 1, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000101, 0, 0, 1'b0);
        run_instr(6'b001101, 2, 0, 1'b1);
        run_instr(6'b001010, 0, 0, 1'b0);
        run_instr(6'b101011, 0, 2, 1'b0);
        run_instr(6'b000010, 1, 0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000101, 0, 0, 1'b1);
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b001100, 0, 0, 1'b0);

        // lw interrupted by reset while stalled in the memory read
        cyc("fetch", 1, r6(), 1'b1, r1(), mk(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b000), 0);
        cyc("decode", 1, 6'b100011, 1'b0, r1(), mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000), 0);
        cyc("lw_addr", 1, 6'b100011, 1'b0, r1(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000), 0);
        cyc("mem_rd_wait", 1, 6'b100011, 1'b0, r1(), mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000), 0);
        cyc("mid_reset", 0, 6'b100011, 1'b0, r1(), zero_e, 0);
        cyc("idle_after_reset", 1, r6(), r1(), r1(), zero_e, 0);
        run_instr(6'b000000, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++)
            run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 2),
                      $urandom_range(0, 3), r1());

        run_instr(6'b111111, 1, 0, 1'b0);

        cyc("reset", 0, 6'd0, r1(), r1(), zero_e, 0);
        cyc("idle", 1, r6(), r1(), r1(), zero_e, 0);
        run_instr(6'b100011, 0, 1, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses never compared", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
